// File: rtl/conv_pool_sequencer.sv
// Convolution + max-pool layer sequencer.
// Drives the address generator one kernel tap per cycle, lines the MAC and
// pool-compare enables up with the memory read latency, and hands each pooled
// result downstream over a valid/ready handshake.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for go_i; address generator held at first address
// S_RUN   | issuing taps (frozen while a result waits for out_ready_i)
// S_DRAIN | all taps issued; in-flight taps and final result draining
// S_DONE  | one-cycle completion pulse, then back to S_IDLE
//
// All counts (TAPS, POOL_WIN, POOL_OUTS, MAPS) must be at least 2 so every
// counter has a non-zero width.
module conv_pool_sequencer #(
   parameter int TAPS      = 25,
   parameter int POOL_WIN  = 4,
   parameter int POOL_OUTS = 144,
   parameter int MAPS      = 16,
   parameter int MEM_LAT   = 1
) (
   input  logic                          clk,
   input  logic                          n_reset,
   input  logic                          go_i,
   input  logic                          abort_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          agen_start_o,
   output logic                          agen_hold_o,
   output logic                          mac_en_o,
   output logic                          mac_clr_o,
   output logic                          pool_en_o,
   output logic                          pool_clr_o,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [$clog2(MAPS)-1:0]       out_map_o,
   output logic [$clog2(POOL_OUTS)-1:0]  out_idx_o
);

   localparam int TW = $clog2(TAPS);
   localparam int CW = $clog2(POOL_WIN);
   localparam int OW = $clog2(POOL_OUTS);
   localparam int MW = $clog2(MAPS);

   localparam logic [TW-1:0] TAP_MAX  = TW'(TAPS - 1);
   localparam logic [CW-1:0] CONV_MAX = CW'(POOL_WIN - 1);
   localparam logic [OW-1:0] POUT_MAX = OW'(POOL_OUTS - 1);
   localparam logic [MW-1:0] MAP_MAX  = MW'(MAPS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t state_q, state_d;

   // issue-side counters: tap within conv within pooled output within map
   logic [TW-1:0] tap_q,  tap_d;
   logic [CW-1:0] conv_q, conv_d;
   logic [OW-1:0] pout_q, pout_d;
   logic [MW-1:0] map_q,  map_d;

   // read-latency delay line carrying {valid, first_tap, last_tap}
   logic [MEM_LAT-1:0] dl_vld_q,   dl_vld_d;
   logic [MEM_LAT-1:0] dl_first_q, dl_first_d;
   logic [MEM_LAT-1:0] dl_last_q,  dl_last_d;

   // pool side: window element counter and registered enables
   logic [CW-1:0] win_q, win_d;
   logic          pool_en_q,   pool_en_d;
   logic          pool_clr_q,  pool_clr_d;
   logic          pool_last_q, pool_last_d;

   // result side
   logic          out_valid_q, out_valid_d;
   logic [OW-1:0] res_idx_q,   res_idx_d;
   logic [MW-1:0] res_map_q,   res_map_d;

   logic run;
   logic hold;
   logic issue;
   logic last_issue;
   logic accept;
   logic res_last;
   logic tail_last;

   assign run        = (state_q == S_RUN);
   assign hold       = run && out_valid_q && !out_ready_i;
   assign issue      = run && !hold;
   assign last_issue = issue && (tap_q == TAP_MAX) && (conv_q == CONV_MAX) &&
                       (pout_q == POUT_MAX) && (map_q == MAP_MAX);
   assign accept     = out_valid_q && out_ready_i;
   assign res_last   = (res_idx_q == POUT_MAX) && (res_map_q == MAP_MAX);
   assign tail_last  = dl_vld_q[MEM_LAT-1] && dl_last_q[MEM_LAT-1];

   assign busy_o       = (state_q != S_IDLE);
   assign done_o       = (state_q == S_DONE);
   assign agen_start_o = run;
   assign agen_hold_o  = hold;
   assign mac_en_o     = dl_vld_q[MEM_LAT-1];
   assign mac_clr_o    = dl_vld_q[MEM_LAT-1] && dl_first_q[MEM_LAT-1];
   assign pool_en_o    = pool_en_q;
   assign pool_clr_o   = pool_clr_q;
   assign out_valid_o  = out_valid_q;
   assign out_map_o    = res_map_q;
   assign out_idx_o    = res_idx_q;

   // state register
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic; abort wins over everything including go
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (go_i) state_d = S_RUN;
         S_RUN:   if (last_issue) state_d = S_DRAIN;
         S_DRAIN: if (accept && res_last) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (abort_i) begin
         state_d = S_IDLE;
      end
   end

   // nested issue counters, stepping once per issued tap
   always_comb begin
      tap_d  = tap_q;
      conv_d = conv_q;
      pout_d = pout_q;
      map_d  = map_q;
      if (abort_i || (state_q == S_IDLE)) begin
         tap_d  = '0;
         conv_d = '0;
         pout_d = '0;
         map_d  = '0;
      end else if (issue) begin
         if (tap_q == TAP_MAX) begin
            tap_d = '0;
            if (conv_q == CONV_MAX) begin
               conv_d = '0;
               if (pout_q == POUT_MAX) begin
                  pout_d = '0;
                  map_d  = (map_q == MAP_MAX) ? '0 : map_q + 1'b1;
               end else begin
                  pout_d = pout_q + 1'b1;
               end
            end else begin
               conv_d = conv_q + 1'b1;
            end
         end else begin
            tap_d = tap_q + 1'b1;
         end
      end
   end

   // datapath alignment: delay line, pool enables and result handshake
   always_comb begin
      dl_vld_d      = '0;
      dl_first_d    = '0;
      dl_last_d     = '0;
      dl_vld_d[0]   = issue;
      dl_first_d[0] = issue && (tap_q == '0);
      dl_last_d[0]  = issue && (tap_q == TAP_MAX);
      for (int i = 1; i < MEM_LAT; i++) begin
         dl_vld_d[i]   = dl_vld_q[i-1];
         dl_first_d[i] = dl_first_q[i-1];
         dl_last_d[i]  = dl_last_q[i-1];
      end

      pool_en_d   = tail_last;
      pool_clr_d  = tail_last && (win_q == '0);
      pool_last_d = tail_last && (win_q == CONV_MAX);
      win_d       = win_q;
      if (tail_last) begin
         win_d = (win_q == CONV_MAX) ? '0 : win_q + 1'b1;
      end

      // a completed window never lands on a pending result, so set/clear
      // cannot both be needed for the same result
      out_valid_d = out_valid_q;
      if (accept) begin
         out_valid_d = 1'b0;
      end
      if (pool_en_q && pool_last_q) begin
         out_valid_d = 1'b1;
      end

      res_idx_d = res_idx_q;
      res_map_d = res_map_q;
      if (accept) begin
         if (res_idx_q == POUT_MAX) begin
            res_idx_d = '0;
            res_map_d = (res_map_q == MAP_MAX) ? '0 : res_map_q + 1'b1;
         end else begin
            res_idx_d = res_idx_q + 1'b1;
         end
      end

      if (abort_i) begin
         dl_vld_d    = '0;
         dl_first_d  = '0;
         dl_last_d   = '0;
         pool_en_d   = 1'b0;
         pool_clr_d  = 1'b0;
         pool_last_d = 1'b0;
         win_d       = '0;
         out_valid_d = 1'b0;
         res_idx_d   = '0;
         res_map_d   = '0;
      end
   end

   // counter and pipeline registers
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         tap_q       <= '0;
         conv_q      <= '0;
         pout_q      <= '0;
         map_q       <= '0;
         dl_vld_q    <= '0;
         dl_first_q  <= '0;
         dl_last_q   <= '0;
         win_q       <= '0;
         pool_en_q   <= 1'b0;
         pool_clr_q  <= 1'b0;
         pool_last_q <= 1'b0;
         out_valid_q <= 1'b0;
         res_idx_q   <= '0;
         res_map_q   <= '0;
      end else begin
         tap_q       <= tap_d;
         conv_q      <= conv_d;
         pout_q      <= pout_d;
         map_q       <= map_d;
         dl_vld_q    <= dl_vld_d;
         dl_first_q  <= dl_first_d;
         dl_last_q   <= dl_last_d;
         win_q       <= win_d;
         pool_en_q   <= pool_en_d;
         pool_clr_q  <= pool_clr_d;
         pool_last_q <= pool_last_d;
         out_valid_q <= out_valid_d;
         res_idx_q   <= res_idx_d;
         res_map_q   <= res_map_d;
      end
   end

   // a full window takes at least TAPS*POOL_WIN issue cycles, which must
   // cover the latency from issue to out_valid plus the accept cycle
   a_param_spacing: assert property (@(posedge clk) (TAPS * POOL_WIN) >= (MEM_LAT + 3));

   // a newly completed window must never overwrite a pending result
   a_no_collision: assert property (@(posedge clk) disable iff (!n_reset)
      !(pool_en_q && pool_last_q && out_valid_q && !out_ready_i));

endmodule

// File: doc/conv_pool_sequencer.md
# conv_pool_sequencer

Top-level controller for one convolution + max-pool layer pass. It starts and stalls the convolution address generator and aligns MAC and pooling enables to the image-memory read latency. It emits one pooled result per window over a valid/ready handshake and reports completion. It sits between the layer-level control and the address generator / MAC / pool-compare datapath.

## Interface
- TAPS, 25: kernel taps per convolution output (5x5).
- POOL_WIN, 4: convolution outputs per pooling window (2x2).
- POOL_OUTS, 144: pooled outputs per feature map (12x12).
- MAPS, 16: feature maps per layer pass.
- MEM_LAT, 1: image/weight memory read latency in cycles (>=1).
- clk  in  1  clock, rising edge.
- n_reset  in  1  reset n_reset, asynchronous, active-low.
- go  in  1  start a layer pass; sampled only in IDLE.
- abort  in  1  synchronous abort; return to IDLE next cycle.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the pass completes.
- agen_start  out  1  address generator run; low resets the generator to its first address.
- agen_hold  out  1  freeze the address generator for this cycle.
- mac_en  out  1  MAC accumulates the memory data present this cycle.
- mac_clr  out  1  with mac_en: load the product instead of adding it (first tap).
- pool_en  out  1  MAC result valid; pool unit compares it.
- pool_clr  out  1  with pool_en: load instead of max (first window element).
- out_valid  out  1  pooled result valid.
- out_ready  in  1  downstream accepts the result.
- out_map  out  $clog2(MAPS)  map index of the current result.
- out_idx  out  $clog2(POOL_OUTS)  index within the map of the current result.

## Operation
- Reset: state IDLE; every output 0; all counters 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on go=1. go in any other state is ignored.
- RUN: agen_start=1. Each cycle with agen_hold=0 issues one tap. Issue counters nest: tap (0..TAPS-1) within conv (0..POOL_WIN-1) within pooled output (0..POOL_OUTS-1) within map (0..MAPS-1).
- Issue of the final tap (all counters at maximum) -> DRAIN. agen_start=0 from the next cycle.
- Alignment: each issued tap creates a flag pair {first_tap, last_tap} in a MEM_LAT-deep delay line.
  - Delayed flag valid: mac_en=1; mac_clr=first_tap.
  - Cycle after a delayed last_tap: pool_en=1; pool_clr=1 for window element 0.
- Cycle after pool_en for window element POOL_WIN-1: out_valid=1, with out_map/out_idx taken from the result counters. Hold until out_valid && out_ready; the result counters advance on acceptance.
- Backpressure: agen_hold = out_valid && !out_ready while in RUN. Taps already in flight still drain through mac_en/pool_en. No pool_en can collide with a pending out_valid, because TAPS*POOL_WIN >= MEM_LAT+3 is required (checked by assertion).
- DRAIN -> DONE on acceptance of result MAPS*POOL_OUTS-1. DONE lasts one cycle with done=1, then -> IDLE.
- abort=1 in any state: next cycle is IDLE. All outputs 0, delay line and counters cleared, no done pulse. abort overrides go.
- Asynchronous reset mid-pass behaves as abort, but takes effect immediately.

## Timing
- go sampled at edge 0: agen_start=1 from cycle 1. Tap k of conv c (no stall) issues at cycle 1+TAPS*c+k.
- mac_en for that tap falls at issue+MEM_LAT. pool_en for conv c falls at 1+TAPS*(c+1)+MEM_LAT.
- Defaults, out_ready=1:
  - First pool_en: cycle 27.
  - First out_valid: cycle 103.
  - out_valid repeats every 100 cycles.
  - Last issue: cycle 230400. Last out_valid: cycle 230403. done: cycle 230404.
- Each stalled cycle delays every later event by one cycle.
- busy rises the cycle after go and falls the cycle after done.

## Test plan
- Defaults, out_ready=1, go at cycle 0:
  - mac_en/mac_clr first seen at cycle 2. pool_en/pool_clr at 27. pool_en (no clr) at 52.
  - out_valid at 103 with out_map=0, out_idx=0.
  - done at 230404. Exactly 2304 results, indices sequential.
- TAPS=2, POOL_WIN=2, POOL_OUTS=2, MAPS=2, out_ready=0 on the first out_valid for 5 cycles:
  - agen_hold high those 5 cycles. Result held stable.
  - Total done delayed by 5 cycles. No pool_en while out_valid is pending.
- abort at cycle 50 of a default pass: cycle 51 shows all outputs 0 and busy=0, no done. A new go restarts from out_idx=0.
- MEM_LAT=3, small params: mac_en lags each issue by exactly 3 cycles. The mac_clr count equals the conv count.
- go pulsed during RUN and DRAIN: no effect, single done. go in the DONE cycle is ignored; go in the following IDLE starts a new pass.
- n_reset asserted mid-RUN: outputs 0 asynchronously. After release the block stays in IDLE until go.
